// File: rtl/execute_alu_pipe.sv
// Elastic execute ALU: registered operands in S0, ALU on S0,
// result carried through STAGES-1 more registers to the ROB writeback bus.
module execute_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int FID_W  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_src0_value,
  input  logic [DATA_W-1:0] i_src1_value,
  input  logic [15:0]       i_imm,
  input  logic              i_use_imm,
  input  logic [3:0]        i_alu_cmd,
  input  logic              i_trap_ovf,
  input  logic [ROB_W-1:0]  i_dst_rob,
  input  logic [FID_W-1:0]  i_fid,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_exc,
  output logic [ROB_W-1:0]  o_dst_rob,
  output logic [FID_W-1:0]  o_fid,
  output logic              o_fwd_valid,
  output logic [ROB_W-1:0]  o_fwd_rob,
  output logic [DATA_W-1:0] o_fwd_value
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int LAST = STAGES - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd12;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] en;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [15:0]       imm_q;
  logic              use_imm_q;
  logic              trap_q;
  logic [3:0]        cmd_q;
  logic [ROB_W-1:0]  rob_q;
  logic [FID_W-1:0]  fid_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_exc;

  // A stage may load when it, or any stage downstream, has a hole.
  always_comb begin : enables
    logic acc;
    acc = i_ready;
    en = '0;
    for (int k = LAST; k >= 0; k--) begin
      acc = acc | ~vld[k];
      en[k] = acc;
    end
  end

  assign o_ready = en[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else if (i_flush) begin
      vld <= '0;
    end else begin
      if (en[0]) vld[0] <= i_valid;
      for (int k = 1; k < STAGES; k++)
        if (en[k]) vld[k] <= vld[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      trap_q    <= 1'b0;
      cmd_q     <= '0;
      rob_q     <= '0;
      fid_q     <= '0;
    end else if (!i_flush && en[0] && i_valid) begin
      a_q       <= i_src0_value;
      b_q       <= i_src1_value;
      imm_q     <= i_imm;
      use_imm_q <= i_use_imm;
      trap_q    <= i_trap_ovf;
      cmd_q     <= i_alu_cmd;
      rob_q     <= i_dst_rob;
      fid_q     <= i_fid;
    end
  end

  logic              is_logic;
  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SHAMT_W-1:0] shamt;
  logic              ovf_add;
  logic              ovf_sub;

  always_comb begin
    is_logic = (cmd_q == OP_AND) || (cmd_q == OP_OR) ||
               (cmd_q == OP_XOR) || (cmd_q == OP_NOR);
    imm_sx = {{(DATA_W-16){imm_q[15]}}, imm_q};
    if (!use_imm_q) opb = b_q;
    else if (is_logic) opb = {{(DATA_W-16){1'b0}}, imm_q};
    else opb = imm_sx;
    shamt = use_imm_q ? SHAMT_W'(imm_q[10:6]) : a_q[SHAMT_W-1:0];
    sum  = a_q + opb;
    diff = a_q - opb;
    ovf_add = (a_q[DATA_W-1] == opb[DATA_W-1]) &&
              (sum[DATA_W-1] != a_q[DATA_W-1]);
    ovf_sub = (a_q[DATA_W-1] != opb[DATA_W-1]) &&
              (diff[DATA_W-1] != a_q[DATA_W-1]);
    alu_res = '0;
    alu_exc = 1'b0;
    case (cmd_q)
      OP_ADD: begin
        alu_res = sum;
        alu_exc = trap_q & ovf_add;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_exc = trap_q & ovf_sub;
      end
      OP_AND:  alu_res = a_q & opb;
      OP_OR:   alu_res = a_q | opb;
      OP_XOR:  alu_res = a_q ^ opb;
      OP_NOR:  alu_res = ~(a_q | opb);
      OP_SLT:  alu_res = DATA_W'($signed(a_q) < $signed(opb));
      OP_SLTU: alu_res = DATA_W'(a_q < opb);
      OP_SLL:  alu_res = b_q << shamt;
      OP_SRL:  alu_res = b_q >> shamt;
      OP_SRA:  alu_res = $signed(b_q) >>> shamt;
      OP_LUI:  alu_res = imm_sx << 16;
      OP_PASS: alu_res = a_q;
      default: ;
    endcase
  end

  // Excepting ops must never reach the bypass network.
  assign o_fwd_valid = vld[0] & ~alu_exc;
  assign o_fwd_rob   = rob_q;
  assign o_fwd_value = alu_res;

  if (STAGES == 1) begin : g_direct
    assign o_valid   = vld[0];
    assign o_result  = alu_res;
    assign o_exc     = alu_exc;
    assign o_dst_rob = rob_q;
    assign o_fid     = fid_q;
  end else begin : g_pipe
    logic [DATA_W-1:0] res_q [STAGES-1];
    logic              exc_q [STAGES-1];
    logic [ROB_W-1:0]  rb_q  [STAGES-1];
    logic [FID_W-1:0]  fd_q  [STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          res_q[k] <= '0;
          exc_q[k] <= 1'b0;
          rb_q[k]  <= '0;
          fd_q[k]  <= '0;
        end
      end else if (!i_flush) begin
        if (en[1] && vld[0]) begin
          res_q[0] <= alu_res;
          exc_q[0] <= alu_exc;
          rb_q[0]  <= rob_q;
          fd_q[0]  <= fid_q;
        end
        for (int k = 2; k < STAGES; k++) begin
          if (en[k] && vld[k-1]) begin
            res_q[k-1] <= res_q[k-2];
            exc_q[k-1] <= exc_q[k-2];
            rb_q[k-1]  <= rb_q[k-2];
            fd_q[k-1]  <= fd_q[k-2];
          end
        end
      end
    end

    assign o_valid   = vld[LAST];
    assign o_result  = res_q[STAGES-2];
    assign o_exc     = exc_q[STAGES-2];
    assign o_dst_rob = rb_q[STAGES-2];
    assign o_fid     = fd_q[STAGES-2];
  end

endmodule

// File: tb/tb_execute_alu_pipe.sv
// Bench for execute_alu_pipe: a 32-bit 2-stage instance and a
// 64-bit 3-stage instance, vector tables plus a random scoreboard.
module tb_execute_alu_pipe;
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  cmd;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] imm;
    logic        ui;
    logic        trap;
    logic [63:0] res;
    logic        exc;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
    logic [3:0]  rob;
    logic [7:0]  fid;
  } exp_t;

  int passed = 0;
  int total = 0;

  // 32-bit, STAGES=2 instance
  logic        rst_a, a_valid, a_ready, a_use_imm, a_trap, a_flush;
  logic        a_ovalid, a_iready, a_exc, a_fwv;
  logic [31:0] a_src0, a_src1, a_res, a_fwval;
  logic [15:0] a_imm;
  logic [3:0]  a_cmd, a_rob, a_orob, a_fwr;
  logic [7:0]  a_fid, a_ofid;

  execute_alu_pipe #(.DATA_W(32), .ROB_W(4), .FID_W(8), .STAGES(2)) dut_a (
    .clk(clk), .reset(rst_a), .i_valid(a_valid), .o_ready(a_ready),
    .i_src0_value(a_src0), .i_src1_value(a_src1), .i_imm(a_imm),
    .i_use_imm(a_use_imm), .i_alu_cmd(a_cmd), .i_trap_ovf(a_trap),
    .i_dst_rob(a_rob), .i_fid(a_fid), .i_flush(a_flush),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_result(a_res),
    .o_exc(a_exc), .o_dst_rob(a_orob), .o_fid(a_ofid),
    .o_fwd_valid(a_fwv), .o_fwd_rob(a_fwr), .o_fwd_value(a_fwval)
  );

  // 64-bit, STAGES=3 instance
  logic        rst_b, b_valid, b_ready, b_use_imm, b_trap, b_flush;
  logic        b_ovalid, b_iready, b_exc, b_fwv;
  logic [63:0] b_src0, b_src1, b_res, b_fwval;
  logic [15:0] b_imm;
  logic [3:0]  b_cmd, b_rob, b_orob, b_fwr;
  logic [7:0]  b_fid, b_ofid;

  execute_alu_pipe #(.DATA_W(64), .ROB_W(4), .FID_W(8), .STAGES(3)) dut_b (
    .clk(clk), .reset(rst_b), .i_valid(b_valid), .o_ready(b_ready),
    .i_src0_value(b_src0), .i_src1_value(b_src1), .i_imm(b_imm),
    .i_use_imm(b_use_imm), .i_alu_cmd(b_cmd), .i_trap_ovf(b_trap),
    .i_dst_rob(b_rob), .i_fid(b_fid), .i_flush(b_flush),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_result(b_res),
    .o_exc(b_exc), .o_dst_rob(b_orob), .o_fid(b_ofid),
    .o_fwd_valid(b_fwv), .o_fwd_rob(b_fwr), .o_fwd_value(b_fwval)
  );

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic signed [65:0] sx(input logic [63:0] x,
                                            input int w);
    logic signed [65:0] v;
    if (w == 32) v = $signed(x[31:0]);
    else v = $signed(x);
    return v;
  endfunction

  // Reference ALU from the opcode table, using wide signed arithmetic.
  task automatic ref_alu(input int w, input logic [63:0] a,
                         input logic [63:0] b, input logic [15:0] imm,
                         input logic ui, input logic [3:0] cmd,
                         input logic trap, output logic [63:0] r,
                         output logic e);
    logic [63:0] mask, opb;
    logic signed [65:0] t, lim;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (!ui) opb = b;
    else if (cmd >= 4'd2 && cmd <= 4'd5) opb = {48'h0, imm};
    else opb = {{48{imm[15]}}, imm};
    sh = ui ? int'(imm[10:6]) : int'(a[5:0]) % w;
    lim = 66'sd1 <<< (w - 1);
    r = '0;
    e = 1'b0;
    case (cmd)
      4'd0: begin
        t = sx(a, w) + sx(opb, w);
        r = 64'(t) & mask;
        e = trap && (t >= lim || t < -lim);
      end
      4'd1: begin
        t = sx(a, w) - sx(opb, w);
        r = 64'(t) & mask;
        e = trap && (t >= lim || t < -lim);
      end
      4'd2: r = a & opb & mask;
      4'd3: r = (a | opb) & mask;
      4'd4: r = (a ^ opb) & mask;
      4'd5: r = ~(a | opb) & mask;
      4'd6: r = (sx(a, w) < sx(opb, w)) ? 64'd1 : 64'd0;
      4'd7: r = ((a & mask) < (opb & mask)) ? 64'd1 : 64'd0;
      4'd8: r = (b << sh) & mask;
      4'd9: r = (b & mask) >> sh;
      4'd10: begin
        t = sx(b, w) >>> sh;
        r = 64'(t) & mask;
      end
      4'd11: begin
        t = $signed(imm);
        t = t * 65536;
        r = 64'(t) & mask;
      end
      4'd12: r = a & mask;
      default: r = '0;
    endcase
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic drive_a(input vec_t v, input logic [3:0] rob,
                         input logic [7:0] fid);
    a_cmd = v.cmd;
    a_src0 = v.a[31:0];
    a_src1 = v.b[31:0];
    a_imm = v.imm;
    a_use_imm = v.ui;
    a_trap = v.trap;
    a_rob = rob;
    a_fid = fid;
  endtask

  task automatic drive_b(input vec_t v, input logic [3:0] rob);
    b_cmd = v.cmd;
    b_src0 = v.a;
    b_src1 = v.b;
    b_imm = v.imm;
    b_use_imm = v.ui;
    b_trap = v.trap;
    b_rob = rob;
    b_fid = 8'(rob);
  endtask

  localparam int NT = 17;
  vec_t tv[NT];
  vec_t bv[4];
  vec_t pv;
  exp_t q[$];
  exp_t h;
  logic [63:0] rr;
  logic re;
  int seq;

  initial begin
    tv[0]  = '{4'd0, 64'h7FFF_FFFF, 64'h1, 16'h0, 1'b0, 1'b1, 64'h8000_0000, 1'b1};
    tv[1]  = '{4'd6, 64'hFFFF_FFFF, 64'h1, 16'h0, 1'b0, 1'b0, 64'h1, 1'b0};
    tv[2]  = '{4'd7, 64'hFFFF_FFFF, 64'h1, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    tv[3]  = '{4'd10, 64'h0, 64'h8000_0000, 16'h0100, 1'b1, 1'b0, 64'hF800_0000, 1'b0};
    tv[4]  = '{4'd11, 64'h0, 64'h0, 16'h8000, 1'b1, 1'b0, 64'h8000_0000, 1'b0};
    tv[5]  = '{4'd0, 64'h7FFF_FFFF, 64'h1, 16'h0, 1'b0, 1'b0, 64'h8000_0000, 1'b0};
    tv[6]  = '{4'd1, 64'h8000_0000, 64'h1, 16'h0, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1};
    tv[7]  = '{4'd2, 64'hFFFF_FFFF, 64'h0, 16'hFFFF, 1'b1, 1'b0, 64'h0000_FFFF, 1'b0};
    tv[8]  = '{4'd0, 64'h5, 64'h0, 16'hFFFF, 1'b1, 1'b1, 64'h4, 1'b0};
    tv[9]  = '{4'd5, 64'h0F0F_0F0F, 64'hF0F0_F0F0, 16'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    tv[10] = '{4'd8, 64'h4, 64'h3, 16'h0, 1'b0, 1'b0, 64'h30, 1'b0};
    tv[11] = '{4'd9, 64'h1F, 64'h8000_0000, 16'h0, 1'b0, 1'b0, 64'h1, 1'b0};
    tv[12] = '{4'd12, 64'hDEAD_BEEF, 64'h0, 16'h0, 1'b0, 1'b0, 64'hDEAD_BEEF, 1'b0};
    tv[13] = '{4'd14, 64'h1234_5678, 64'h1, 16'h0, 1'b0, 1'b1, 64'h0, 1'b0};
    tv[14] = '{4'd4, 64'hFF00_FF00, 64'h0F0F_0F0F, 16'h0, 1'b0, 1'b0, 64'hF00F_F00F, 1'b0};
    tv[15] = '{4'd3, 64'h0, 64'h0, 16'h8001, 1'b1, 1'b0, 64'h0000_8001, 1'b0};
    tv[16] = '{4'd6, 64'h0, 64'h0, 16'hFFFF, 1'b1, 1'b0, 64'h0, 1'b0};
    bv[0] = '{4'd8, 64'd63, 64'd1, 16'h0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    bv[1] = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'hFFFF, 1'b1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0};
    bv[2] = '{4'd11, 64'h0, 64'h0, 16'h8000, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0};
    bv[3] = '{4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 16'h0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 1'b0; a_flush = 1'b0; a_iready = 1'b0;
    b_valid = 1'b0; b_flush = 1'b0; b_iready = 1'b0;
    drive_a(tv[12], 4'd0, 8'd0);
    drive_b(bv[0], 4'd0);

    @(negedge clk);
    chk("rst_a_valid", a_ovalid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_a_fwd", a_fwv, 1'b0);
    chk("rst_a_payload", {a_res, a_exc, a_orob, a_ofid}, '0);
    chk("rst_b_state", {b_ovalid, b_ready, b_fwv, b_exc}, 4'b0100);
    chk("rst_b_payload", {b_res, b_orob, b_ofid}, '0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // back-to-back table through the 2-stage instance
    a_iready = 1'b1;
    for (int c = 0; c < NT + 2; c++) begin
      @(posedge clk); #1;
      a_valid = (c < NT);
      if (c < NT) drive_a(tv[c], c[3:0], 8'(c + 16));
      @(negedge clk);
      if (c >= 1 && c <= NT) begin
        chk($sformatf("tbl_fwd%0d", c - 1), {a_fwv, a_fwr},
            {~tv[c-1].exc, 4'(c - 1)});
        if (!tv[c-1].exc)
          chk($sformatf("tbl_fwdval%0d", c - 1), a_fwval, tv[c-1].res);
      end
      if (c < 2) chk("tbl_latency", a_ovalid, 1'b0);
      else chk($sformatf("tbl_out%0d", c - 2),
               {a_ovalid, a_res, a_exc, a_orob, a_ofid},
               {1'b1, tv[c-2].res[31:0], tv[c-2].exc, 4'(c - 2), 8'(c + 14)});
    end

    // flush with two in flight plus one offered
    pv = tv[12];
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      a_valid = (c <= 2) || (c == 5);
      a_flush = (c == 2);
      pv.a = 64'(100 + c);
      drive_a(pv, c[3:0], 8'(c));
      @(negedge clk);
      if (c == 2)
        chk("flush_xfer", {a_ovalid, a_res, a_orob}, {1'b1, 32'd100, 4'd0});
      if (c >= 3 && c <= 6) chk($sformatf("flush_empty%0d", c), a_ovalid, 1'b0);
      if (c == 7)
        chk("flush_after", {a_ovalid, a_res, a_orob}, {1'b1, 32'd105, 4'd5});
    end

    // reset with S0 and S1 both valid
    a_iready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      a_valid = 1'b1;
      pv.a = 64'(200 + c);
      drive_a(pv, c[3:0], 8'(c));
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_before", {a_ovalid, a_fwv, a_ready}, 3'b110);
    #1 rst_a = 1'b1;
    #1 chk("rstmid_now", {a_ovalid, a_fwv, a_ready}, 3'b001);
    @(posedge clk); #1;
    rst_a = 1'b0;
    a_iready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid_empty", a_ovalid, 1'b0);
    end

    // random scoreboard run
    seq = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      a_valid = ($urandom_range(0, 9) < 7);
      a_iready = ($urandom_range(0, 9) < 7);
      a_flush = ($urandom_range(0, 24) == 0);
      a_cmd = 4'($urandom_range(0, 15));
      a_src0 = pick32();
      a_src1 = pick32();
      a_imm = 16'($urandom());
      a_use_imm = $urandom_range(0, 1) == 1;
      a_trap = $urandom_range(0, 1) == 1;
      a_rob = 4'($urandom());
      a_fid = 8'(seq);
      @(negedge clk);
      chk("rnd_ready", a_ready, a_iready || q.size() < 2);
      if (a_ovalid && q.size() == 0) chk("rnd_spurious", 1'b1, 1'b0);
      if (a_ovalid && a_iready && q.size() > 0) begin
        h = q.pop_front();
        chk("rnd_out", {a_res, a_exc, a_orob, a_ofid}, h);
      end
      if (a_flush) q.delete();
      if (a_valid && a_ready && !a_flush) begin
        ref_alu(32, {32'h0, a_src0}, {32'h0, a_src1}, a_imm, a_use_imm,
                a_cmd, a_trap, rr, re);
        q.push_back({rr[31:0], re, a_rob, a_fid});
        seq++;
      end
    end
    a_valid = 1'b0;
    a_flush = 1'b0;
    a_iready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (a_ovalid) begin
        h = q.pop_front();
        chk("rnd_drain", {a_res, a_exc, a_orob, a_ofid}, h);
      end
    end
    chk("rnd_drained", q.size(), 0);

    // 64-bit, 3-stage backpressure fill and drain
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      b_iready = (c >= 4);
      b_valid = (c <= 4);
      drive_b(bv[(c < 3) ? c : 3], 4'((c < 3) ? c : 3));
      @(negedge clk);
      if (c <= 2) chk($sformatf("bp_ready%0d", c), b_ready, 1'b1);
      if (c == 3) chk("bp_full", b_ready, 1'b0);
      if (c == 4) chk("bp_release", b_ready, 1'b1);
      if (c == 2) chk("bp_not_yet", b_ovalid, 1'b0);
      if (c >= 3 && c <= 7)
        chk($sformatf("bp_out%0d", c), {b_ovalid, b_res, b_exc, b_orob},
            {1'b1, bv[(c == 3) ? 0 : c - 4].res, bv[(c == 3) ? 0 : c - 4].exc,
             4'((c == 3) ? 0 : c - 4)});
      if (c == 8) chk("bp_no_dup", b_ovalid, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
